secret_op_sequencer: RTL and testbench



---
 rtl/secret_seq_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/secret_op_sequencer.sv | 158 +++++++++++++++
 tb/tb_secret_op_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secret_seq_pkg.sv
// ============================================================================
//  Module      : secret_seq_pkg
//  Description : Shared types and helpers for the secret datapath sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package secret_seq_pkg;

    // Widest requester index a tag can carry; supports up to 256 requesters.
    localparam int ID_MAX_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
    } seq_tag_t;

    function automatic int ID_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin grant starting at a given pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
    import secret_seq_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]       req,
    input  logic [ID_W(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]       gnt,
    output logic [ID_W(NREQ)-1:0] idx,
    output logic                  any
);

    localparam int IDW = ID_W(NREQ);

    // Two passes: positions at/after ptr first, then the wrapped-around ones.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!any && (j >= int'(ptr)) && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!any && (j < int'(ptr)) && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/secret_op_sequencer.sv
// ============================================================================
//  Module      : secret_op_sequencer
//  Description : Round-robin operand sequencer with tagged fixed-latency return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module secret_op_sequencer
    import secret_seq_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int LAT     = 1,
    parameter int MAX_OPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]      dp_a,
    output logic [WIDTH-1:0]      dp_b,
    input  logic [WIDTH-1:0]      dp_x,
    output logic                  rsp_valid,
    output logic [ID_W(NREQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]      rsp_x,
    output logic [31:0]           op_count,
    output logic                  done
);

    localparam int             IDW       = ID_W(NREQ);
    localparam logic [31:0]    C_MAX_OPS = 32'(MAX_OPS);
    localparam logic [IDW-1:0] C_LAST_ID = IDW'(NREQ - 1);

    seq_state_t       r_state;
    logic [IDW-1:0]   r_ptr;
    seq_tag_t         r_tags [LAT];
    logic [WIDTH-1:0] r_dp_a;
    logic [WIDTH-1:0] r_dp_b;
    logic             r_rsp_valid;
    logic [IDW-1:0]   r_rsp_id;
    logic [31:0]      r_op_count;
    logic             r_done;

    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_pipe_busy;
    seq_tag_t         w_new_tag;
    logic             w_tag_unused;

    assign w_req = (r_state == RUN && !rst) ? req_valid : '0;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req (w_req),
        .ptr (r_ptr),
        .gnt (w_gnt),
        .idx (w_idx),
        .any (w_xfer)
    );

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_a = req_a[i*WIDTH +: WIDTH];
                w_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            if (r_tags[s].valid) begin
                w_pipe_busy = 1'b1;
            end
        end
    end

    assign w_new_tag.valid = w_xfer;
    assign w_new_tag.id    = ID_MAX_W'(w_idx);

    // Only the low IDW bits of the tag id ever reach the response port.
    assign w_tag_unused = ^r_tags[LAT-1].id;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_ptr       <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_op_count  <= '0;
            r_done      <= 1'b0;
            for (int s = 0; s < LAT; s++) begin
                r_tags[s] <= '0;
            end
        end else begin
            r_tags[0] <= w_new_tag;
            for (int s = 1; s < LAT; s++) begin
                r_tags[s] <= r_tags[s-1];
            end
            // Extra register stage aligns the tag with dp_x (operands are registered first).
            r_rsp_valid <= r_tags[LAT-1].valid;
            r_rsp_id    <= r_tags[LAT-1].id[IDW-1:0];

            if (w_xfer) begin
                r_dp_a <= w_a;
                r_dp_b <= w_b;
                r_ptr  <= (w_idx == C_LAST_ID) ? '0 : w_idx + IDW'(1);
                if (r_op_count != '1) begin
                    r_op_count <= r_op_count + 32'd1;
                end
            end

            case (r_state)
                RUN: begin
                    if ((MAX_OPS != 0) && w_xfer && (r_op_count + 32'd1 == C_MAX_OPS)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_rsp_valid && !w_pipe_busy) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_x     = dp_x;
    assign op_count  = r_op_count;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_secret_op_sequencer.sv
// ============================================================================
//  Module      : tb_secret_op_sequencer
//  Description : Self-checking bench; instance 0 has LAT=1/MAX_OPS=3, instance 1 LAT=3/MAX_OPS=0.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_secret_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst [2];
    logic [3:0]   vld [2];
    logic [127:0] ra  [2];
    logic [127:0] rb  [2];
    logic [3:0]   rdy [2];
    logic [31:0]  dpa [2];
    logic [31:0]  dpb [2];
    logic [31:0]  rx  [2];
    logic [31:0]  cnt [2];
    logic         rv  [2];
    logic         dn  [2];
    logic [1:0]   rid [2];
    logic [31:0]  x0, x1, p1, p2;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        int          due;
        int          id;
        logic [31:0] x;
    } exp_t;

    secret_op_sequencer #(.NREQ(4), .WIDTH(32), .LAT(1), .MAX_OPS(3)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_valid(vld[0]), .req_ready(rdy[0]),
        .req_a(ra[0]), .req_b(rb[0]), .dp_a(dpa[0]), .dp_b(dpb[0]), .dp_x(x0),
        .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_x(rx[0]), .op_count(cnt[0]), .done(dn[0])
    );

    secret_op_sequencer #(.NREQ(4), .WIDTH(32), .LAT(3), .MAX_OPS(0)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_valid(vld[1]), .req_ready(rdy[1]),
        .req_a(ra[1]), .req_b(rb[1]), .dp_a(dpa[1]), .dp_b(dpb[1]), .dp_x(x1),
        .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_x(rx[1]), .op_count(cnt[1]), .done(dn[1])
    );

    // Datapath stand-ins: x = a + b, registered LAT times.
    always @(posedge clk) x0 <= dpa[0] + dpb[0];
    always @(posedge clk) begin
        p1 <= dpa[1] + dpb[1];
        p2 <= p1;
        x1 <= p2;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(input int d);
        return (d == 0) ? 3 : 0;
    endfunction

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        vld[d] = 4'b0;
        @(negedge clk);
        rst[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            vld[d] = 4'hF;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            nvec++; if (rdy[d] !== 4'b0) begin nfail++; $display("FAIL reset_ready d%0d: got %b expected 0000", d, rdy[d]); end
            nvec++; if (dpa[d] !== 32'd0) begin nfail++; $display("FAIL reset_dp_a d%0d: got %h expected 0", d, dpa[d]); end
            nvec++; if (dpb[d] !== 32'd0) begin nfail++; $display("FAIL reset_dp_b d%0d: got %h expected 0", d, dpb[d]); end
            nvec++; if (rv[d] !== 1'b0) begin nfail++; $display("FAIL reset_rsp_valid d%0d: got %b expected 0", d, rv[d]); end
            nvec++; if (rid[d] !== 2'd0) begin nfail++; $display("FAIL reset_rsp_id d%0d: got %0d expected 0", d, rid[d]); end
            nvec++; if (cnt[d] !== 32'd0) begin nfail++; $display("FAIL reset_op_count d%0d: got %0d expected 0", d, cnt[d]); end
            nvec++; if (dn[d] !== 1'b0) begin nfail++; $display("FAIL reset_done d%0d: got %b expected 0", d, dn[d]); end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            vld[d] = 4'b0;
        end
    endtask

    task automatic test_single_op();
        do_reset(0);
        ra[0] = '0; rb[0] = '0;
        ra[0][31:0] = 32'd5; rb[0][31:0] = 32'd7;
        vld[0] = 4'b0001;
        #1;
        nvec++; if (rdy[0] !== 4'b0001) begin nfail++; $display("FAIL single_ready: got %b expected 0001", rdy[0]); end
        @(negedge clk);
        vld[0] = 4'b0;
        #1;
        nvec++; if (dpa[0] !== 32'd5) begin nfail++; $display("FAIL single_dp_a: got %0d expected 5", dpa[0]); end
        nvec++; if (dpb[0] !== 32'd7) begin nfail++; $display("FAIL single_dp_b: got %0d expected 7", dpb[0]); end
        nvec++; if (rv[0] !== 1'b0) begin nfail++; $display("FAIL single_early_rsp: got %b expected 0", rv[0]); end
        @(negedge clk);
        #1;
        nvec++; if (rv[0] !== 1'b1) begin nfail++; $display("FAIL single_rsp_valid: got %b expected 1", rv[0]); end
        nvec++; if (rid[0] !== 2'd0) begin nfail++; $display("FAIL single_rsp_id: got %0d expected 0", rid[0]); end
        nvec++; if (rx[0] !== 32'd12) begin nfail++; $display("FAIL single_rsp_x: got %0d expected 12", rx[0]); end
        nvec++; if (cnt[0] !== 32'd1) begin nfail++; $display("FAIL single_op_count: got %0d expected 1", cnt[0]); end
        @(negedge clk);
        #1;
        nvec++; if (rv[0] !== 1'b0) begin nfail++; $display("FAIL single_rsp_pulse: got %b expected 0", rv[0]); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        do_reset(1);
        for (int r = 0; r < 4; r++) begin
            ra[1][r*32 +: 32] = $urandom();
            rb[1][r*32 +: 32] = $urandom();
        end
        vld[1] = 4'hF;
        for (int k = 0; k < 10; k++) begin
            logic [3:0] eg;
            eg = 4'b0001 << (k % 4);
            #1;
            nvec++; if (rdy[1] !== eg) begin nfail++; $display("FAIL rr_grant cyc %0d: got %b expected %b", k, rdy[1], eg); end
            nvec++; if (rv[1] !== (k >= 4)) begin nfail++; $display("FAIL rr_rsp_valid cyc %0d: got %b expected %b", k, rv[1], (k >= 4)); end
            if (k >= 4) begin
                nvec++; if (rid[1] !== 2'((k - 4) % 4)) begin nfail++; $display("FAIL rr_rsp_id cyc %0d: got %0d expected %0d", k, rid[1], (k - 4) % 4); end
            end
            @(negedge clk);
        end
        vld[1] = 4'b0;
    endtask

    task automatic test_limit_drain();
        logic [31:0] ea [3];
        logic [31:0] eb [3];
        logic [31:0] ex [3];
        ea = '{32'd5, 32'd6, 32'd1};
        eb = '{32'd7, 32'd2, 32'd9};
        ex = '{32'd12, 32'd8, 32'd10};
        do_reset(0);
        ra[0] = '0; rb[0] = '0;
        for (int i = 0; i < 3; i++) begin
            ra[0][(i+1)*32 +: 32] = ea[i];
            rb[0][(i+1)*32 +: 32] = eb[i];
        end
        for (int k = 0; k < 16; k++) begin
            logic [3:0] eg;
            vld[0] = (k < 3) ? (4'b0010 << k) : 4'hF;
            eg     = (k < 3) ? (4'b0010 << k) : 4'b0;
            #1;
            nvec++; if (rdy[0] !== eg) begin nfail++; $display("FAIL limit_grant cyc %0d: got %b expected %b", k, rdy[0], eg); end
            if (k >= 2 && k <= 4) begin
                nvec++; if (rv[0] !== 1'b1) begin nfail++; $display("FAIL limit_rsp_valid cyc %0d: got %b expected 1", k, rv[0]); end
                nvec++; if (rx[0] !== ex[k-2]) begin nfail++; $display("FAIL limit_rsp_x cyc %0d: got %0d expected %0d", k, rx[0], ex[k-2]); end
                nvec++; if (rid[0] !== 2'(k - 1)) begin nfail++; $display("FAIL limit_rsp_id cyc %0d: got %0d expected %0d", k, rid[0], k - 1); end
            end else begin
                nvec++; if (rv[0] !== 1'b0) begin nfail++; $display("FAIL limit_rsp_valid cyc %0d: got %b expected 0", k, rv[0]); end
            end
            nvec++; if (dn[0] !== (k >= 5)) begin nfail++; $display("FAIL limit_done cyc %0d: got %b expected %b", k, dn[0], (k >= 5)); end
            if (k >= 3) begin
                nvec++; if (cnt[0] !== 32'd3) begin nfail++; $display("FAIL limit_op_count cyc %0d: got %0d expected 3", k, cnt[0]); end
            end
            @(negedge clk);
        end
        vld[0] = 4'b0;
    endtask

    task automatic test_lat3_back_to_back();
        do_reset(1);
        ra[1] = '0; rb[1] = '0;
        for (int k = 0; k < 14; k++) begin
            logic ev;
            if (k < 8) begin
                vld[1] = 4'b0100;
                ra[1][64 +: 32] = 32'(k + 1);
                rb[1][64 +: 32] = 32'(100 * (k + 1));
            end else begin
                vld[1] = 4'b0;
            end
            ev = (k >= 4 && k < 12);
            #1;
            nvec++; if (rdy[1] !== ((k < 8) ? 4'b0100 : 4'b0)) begin nfail++; $display("FAIL b2b_grant cyc %0d: got %b", k, rdy[1]); end
            nvec++; if (rv[1] !== ev) begin nfail++; $display("FAIL b2b_rsp_valid cyc %0d: got %b expected %b", k, rv[1], ev); end
            if (ev) begin
                nvec++; if (rx[1] !== 32'(101 * (k - 3))) begin nfail++; $display("FAIL b2b_rsp_x cyc %0d: got %0d expected %0d", k, rx[1], 101 * (k - 3)); end
                nvec++; if (rid[1] !== 2'd2) begin nfail++; $display("FAIL b2b_rsp_id cyc %0d: got %0d expected 2", k, rid[1]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset(1);
        ra[1][32 +: 32] = 32'd3;
        rb[1][32 +: 32] = 32'd4;
        vld[1] = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            nvec++; if (rdy[1] !== 4'b0010) begin nfail++; $display("FAIL mid_grant cyc %0d: got %b expected 0010", k, rdy[1]); end
            @(negedge clk);
        end
        rst[1] = 1'b1;
        vld[1] = 4'hF;
        #1;
        nvec++; if (rdy[1] !== 4'b0) begin nfail++; $display("FAIL mid_ready_in_reset: got %b expected 0000", rdy[1]); end
        nvec++; if (cnt[1] !== 32'd2) begin nfail++; $display("FAIL mid_count_before_reset: got %0d expected 2", cnt[1]); end
        @(negedge clk);
        rst[1] = 1'b0;
        vld[1] = 4'b0;
        for (int k = 3; k < 9; k++) begin
            #1;
            nvec++; if (rv[1] !== 1'b0) begin nfail++; $display("FAIL mid_rsp_valid cyc %0d: got %b expected 0", k, rv[1]); end
            nvec++; if (cnt[1] !== 32'd0) begin nfail++; $display("FAIL mid_op_count cyc %0d: got %0d expected 0", k, cnt[1]); end
            nvec++; if (dn[1] !== 1'b0) begin nfail++; $display("FAIL mid_done cyc %0d: got %b expected 0", k, dn[1]); end
            @(negedge clk);
        end
        vld[1] = 4'hF;
        #1;
        nvec++; if (rdy[1] !== 4'b0001) begin nfail++; $display("FAIL mid_next_grant: got %b expected 0001", rdy[1]); end
        @(negedge clk);
        vld[1] = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_random(input int d, input int ncyc);
        exp_t        q [$];
        int          mptr     = 0;
        int          mcnt     = 0;
        int          last_due = -1;
        logic [31:0] mdpa     = '0;
        logic [31:0] mdpb     = '0;
        do_reset(d);
        for (int k = 0; k < ncyc; k++) begin
            int          g;
            logic [3:0]  eg;
            logic        edone;
            logic        running;
            vld[d] = 4'($urandom_range(0, 15));
            for (int r = 0; r < 4; r++) begin
                ra[d][r*32 +: 32] = $urandom();
                rb[d][r*32 +: 32] = $urandom();
            end
            #1;
            running = (max_of(d) == 0) || (mcnt < max_of(d));
            g = -1;
            if (running) begin
                for (int o = 0; o < 4; o++) begin
                    if (g < 0 && vld[d][(mptr + o) % 4]) g = (mptr + o) % 4;
                end
            end
            eg    = (g >= 0) ? (4'b0001 << g) : 4'b0;
            edone = (max_of(d) != 0) && (mcnt == max_of(d)) && (k > last_due);
            nvec++; if (rdy[d] !== eg) begin nfail++; $display("FAIL rnd_grant d%0d cyc %0d: got %b expected %b", d, k, rdy[d], eg); end
            nvec++; if (dpa[d] !== mdpa || dpb[d] !== mdpb) begin nfail++; $display("FAIL rnd_dp d%0d cyc %0d: got %h/%h expected %h/%h", d, k, dpa[d], dpb[d], mdpa, mdpb); end
            nvec++; if (cnt[d] !== 32'(mcnt)) begin nfail++; $display("FAIL rnd_op_count d%0d cyc %0d: got %0d expected %0d", d, k, cnt[d], mcnt); end
            nvec++; if (dn[d] !== edone) begin nfail++; $display("FAIL rnd_done d%0d cyc %0d: got %b expected %b", d, k, dn[d], edone); end
            if (q.size() > 0 && q[0].due == k) begin
                nvec++; if (rv[d] !== 1'b1 || rid[d] !== 2'(q[0].id) || rx[d] !== q[0].x) begin
                    nfail++; $display("FAIL rnd_rsp d%0d cyc %0d: got v=%b id=%0d x=%h expected v=1 id=%0d x=%h", d, k, rv[d], rid[d], rx[d], q[0].id, q[0].x);
                end
                void'(q.pop_front());
            end else begin
                nvec++; if (rv[d] !== 1'b0) begin nfail++; $display("FAIL rnd_rsp_idle d%0d cyc %0d: got %b expected 0", d, k, rv[d]); end
            end
            if (g >= 0) begin
                exp_t e;
                mdpa  = ra[d][g*32 +: 32];
                mdpb  = rb[d][g*32 +: 32];
                e.due = k + lat_of(d) + 1;
                e.id  = g;
                e.x   = mdpa + mdpb;
                q.push_back(e);
                last_due = e.due;
                mcnt++;
                mptr = (g + 1) % 4;
            end
            @(negedge clk);
        end
        vld[d] = 4'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            vld[d] = 4'b0;
            ra[d]  = '0;
            rb[d]  = '0;
        end
        @(negedge clk);
        test_reset();
        test_single_op();
        test_round_robin();
        test_limit_drain();
        test_lat3_back_to_back();
        test_reset_midflight();
        test_random(0, 40);
        test_random(1, 300);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
